// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d packer: 256 coefficients of d bits each go in, a
// little-endian byte stream of 32*d bytes comes out over a ready/valid port.
module byte_encode_stream #(
  parameter int D_MAX    = 12,
  parameter int N_COEFFS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       d_sel,
  input  logic             coeff_valid,
  input  logic [D_MAX-1:0] coeff_data,
  output logic             coeff_ready,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int ACC_W = 20;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int CC_W  = $clog2(N_COEFFS + 1);
  localparam int BC_W  = $clog2(32 * D_MAX + 1);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CC_W-1:0]  coeff_cnt_q;
  logic [BC_W-1:0]  byte_cnt_q;
  logic [3:0]       d_q;
  logic [7:0]       byte_data_q;
  logic             byte_valid_q;
  logic             byte_last_q;
  logic             done_q;
  logic             err_q;

  logic in_pack, take, move, hs, pack_end, d_legal;

  // Keep only the low d bits of a coefficient, widened to the accumulator.
  function automatic logic [ACC_W-1:0] mask_coeff(input logic [D_MAX-1:0] data,
                                                  input logic [3:0] d);
    logic [ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < D_MAX; i++) begin
      r[i] = data[i] && (i < int'(d));
    end
    return r;
  endfunction

  assign in_pack  = (state_q == PACK);
  assign coeff_ready = in_pack && (acc_cnt_q < CNT_W'(8)) &&
                       (coeff_cnt_q < CC_W'(N_COEFFS));
  assign take     = coeff_valid && coeff_ready;
  assign hs       = byte_valid_q && byte_ready;
  assign move     = in_pack && (acc_cnt_q >= CNT_W'(8)) && (!byte_valid_q || byte_ready);
  assign pack_end = in_pack && (coeff_cnt_q == CC_W'(N_COEFFS)) && (acc_cnt_q == '0);
  assign d_legal  = (d_sel != 4'd0) && (int'(d_sel) <= D_MAX);

  // take and move never coincide: take needs acc_cnt<8, move needs acc_cnt>=8.
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (take) begin
      acc_d     = acc_q | (mask_coeff(coeff_data, d_q) << acc_cnt_q);
      acc_cnt_d = acc_cnt_q + CNT_W'(d_q);
    end else if (move) begin
      acc_d     = acc_q >> 8;
      acc_cnt_d = acc_cnt_q - CNT_W'(8);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      coeff_cnt_q  <= '0;
      byte_cnt_q   <= '0;
      d_q          <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      if (take) begin
        coeff_cnt_q <= coeff_cnt_q + CC_W'(1);
      end
      if (move) begin
        byte_data_q  <= acc_q[7:0];
        byte_valid_q <= 1'b1;
        byte_last_q  <= ((byte_cnt_q + BC_W'(1)) == BC_W'({d_q, 5'b0}));
        byte_cnt_q   <= byte_cnt_q + BC_W'(1);
      end else if (hs) begin
        byte_valid_q <= 1'b0;
        byte_last_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (d_legal) begin
              d_q         <= d_sel;
              acc_q       <= '0;
              acc_cnt_q   <= '0;
              coeff_cnt_q <= '0;
              byte_cnt_q  <= '0;
              state_q     <= PACK;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        PACK: begin
          // The last byte may already be taken in the cycle packing finishes.
          if (pack_end) begin
            if (hs && byte_last_q) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_last  = byte_last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_byte_encode_stream.sv
// Directed bench for byte_encode_stream: a bit-level reference packer fills a
// queue of expected bytes that a monitor pops on every output handshake.
module tb_byte_encode_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  d_sel;
  logic        coeff_valid;
  logic [11:0] coeff_data;
  logic        coeff_ready;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        byte_last;
  logic        busy;
  logic        done;
  logic        err;

  byte_encode_stream #(.D_MAX(12), .N_COEFFS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .d_sel(d_sel),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .byte_last(byte_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          exp_total = 0;
  int          rx_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  rx_bytes [0:511];
  logic [11:0] coeffs [0:255];
  bit          ready_rand = 1'b0;
  bit          held_v = 1'b0;
  logic [7:0]  held_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream readiness: always ready, or a coin flip each cycle.
  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      byte_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", {31'd0, byte_valid}, 32'd1);
        chk("stall_data", {24'd0, byte_data}, {24'd0, held_d});
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", rx_cnt, exp_total);
        end else begin
          chk("byte", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
          chk("last", {31'd0, byte_last}, {31'd0, rx_cnt == exp_total - 1});
        end
        if (rx_cnt < 512) rx_bytes[rx_cnt] = byte_data;
        rx_cnt++;
      end
      held_v = byte_valid && !byte_ready;
      held_d = byte_data;
      if (done) done_cnt++;
    end
  end

  task automatic build_model(input int d);
    logic [7:0] mb [0:383];
    int pos;
    for (int k = 0; k < 384; k++) mb[k] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      for (int b = 0; b < d; b++) begin
        pos = i * d + b;
        mb[pos / 8][pos % 8] = coeffs[i][b];
      end
    end
    exp_q.delete();
    for (int k = 0; k < 32 * d; k++) exp_q.push_back(mb[k]);
    exp_total = 32 * d;
  endtask

  task automatic run_poly(input int d, input int abort_bytes, input bit mid_start);
    int n;
    int done0;
    build_model(d);
    rx_cnt = 0;
    done0  = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    d_sel = 4'(d);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      coeff_data  = coeffs[i];
      coeff_valid = 1'b1;
      n = 0;
      while (!coeff_ready && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      if (!coeff_ready) begin
        chk("coeff_ready_wait", {31'd0, coeff_ready}, 32'd1);
        break;
      end
      if (mid_start && i == 50) begin
        start = 1'b1;
        d_sel = 4'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (abort_bytes > 0 && rx_cnt >= abort_bytes) break;
    end
    coeff_valid = 1'b0;
    if (abort_bytes > 0) return;
    n = 0;
    while (done_cnt == done0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - done0, 1);
    chk("byte_count", rx_cnt, 32 * d);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_outputs_zero(input string phase);
    chk({phase, "_coeff_ready"}, {31'd0, coeff_ready}, 32'd0);
    chk({phase, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    chk({phase, "_byte_data"}, {24'd0, byte_data}, 32'd0);
    chk({phase, "_byte_last"}, {31'd0, byte_last}, 32'd0);
    chk({phase, "_busy"}, {31'd0, busy}, 32'd0);
    chk({phase, "_done"}, {31'd0, done}, 32'd0);
    chk({phase, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rx0;
    rst = 1'b1; start = 1'b0; d_sel = 4'd0; coeff_valid = 1'b0; coeff_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // d=1, alternating 1,0 -> 32 bytes of 0x55
    for (int i = 0; i < 256; i++) coeffs[i] = (i % 2 == 0) ? 12'd1 : 12'd0;
    run_poly(1, 0, 1'b0);
    chk("p55_first", {24'd0, rx_bytes[0]}, 32'h55);
    chk("p55_last", {24'd0, rx_bytes[31]}, 32'h55);

    // d=12 packing, with a start pulse mid-stream that must be ignored
    for (int i = 0; i < 256; i++) coeffs[i] = 12'h000;
    coeffs[0] = 12'hABC;
    coeffs[1] = 12'h123;
    run_poly(12, 0, 1'b1);
    chk("d12_b0", {24'd0, rx_bytes[0]}, 32'hBC);
    chk("d12_b1", {24'd0, rx_bytes[1]}, 32'h3A);
    chk("d12_b2", {24'd0, rx_bytes[2]}, 32'h12);
    chk("d12_b3", {24'd0, rx_bytes[3]}, 32'h00);

    // d=4, upper coefficient bits set and ignored
    for (int i = 0; i < 256; i++) coeffs[i] = 12'hAF0 | 12'((i + 1) % 16);
    run_poly(4, 0, 1'b0);
    chk("d4_b0", {24'd0, rx_bytes[0]}, 32'h21);

    // d=10 random data, without and then with backpressure
    for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom);
    run_poly(10, 0, 1'b0);
    ready_rand = 1'b1;
    run_poly(10, 0, 1'b0);
    ready_rand = 1'b0;

    // Reset after 100 bytes of a d=12 run
    for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom) | 12'h801;
    run_poly(12, 100, 1'b0);
    chk("abort_reached", {31'd0, rx_cnt >= 100}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_outputs_zero("midreset");
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) coeffs[i] = (i % 2 == 0) ? 12'd1 : 12'd0;
    run_poly(1, 0, 1'b0);
    chk("post_reset_first", {24'd0, rx_bytes[0]}, 32'h55);

    // Illegal widths
    rx0 = rx_cnt;
    @(posedge clk); #1;
    start = 1'b1; d_sel = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_d0", {31'd0, err}, 32'd1);
    chk("busy_d0", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("err_d0_clear", {31'd0, err}, 32'd0);
    start = 1'b1; d_sel = 4'd13;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_d13", {31'd0, err}, 32'd1);
    chk("busy_d13", {31'd0, busy}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("err_d13_clear", {31'd0, err}, 32'd0);
    chk("illegal_no_bytes", rx_cnt, rx0);
    chk("illegal_no_valid", {31'd0, byte_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
